// File: rtl/result_display_latch.sv
// Display latch at the end of the calculator datapath.
// A debounced press of the raw KEY snapshots the calculator result, converts it
// to two BCD digits with a one-bit-per-cycle double-dabble, and drives two
// active-low seven-segment displays (tens on segA, ones on segB).
module result_display_latch #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLANK_LZ        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] result,
    input  logic             btn_n,
    output logic [6:0]       segA,
    output logic [6:0]       segB,
    output logic [7:0]       bcd,
    output logic             busy,
    output logic             done
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // WIDTH is at most 6, so three bits always hold the iteration index.
    localparam int IT_W = 3;
    localparam logic [IT_W-1:0] IT_LAST = IT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_UPDATE
    } state_t;

    // Button path
    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb;
    logic [DB_W-1:0] r_cnt;
    logic            r_press;

    // Conversion datapath
    state_t          r_state;
    logic [WIDTH-1:0] r_shift;
    logic [7:0]      r_acc;
    logic [IT_W-1:0] r_iter;

    // Combinational helpers
    logic [3:0]      w_tens_adj;
    logic [3:0]      w_ones_adj;
    logic [7:0]      w_acc_next;
    logic            w_unused_tens_msb;
    logic [6:0]      w_seg_tens;
    logic [6:0]      w_seg_ones;

    // Active-low seven-segment pattern, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Synchronize the raw button, debounce it and emit a one-cycle strobe on a 1->0 flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_deb   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_deb) begin
                if (r_cnt == DB_LAST) begin
                    r_deb   <= r_sync2;
                    r_cnt   <= '0;
                    // Only the press direction produces an event; releases are silent.
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // One double-dabble step: add 3 to any digit >= 5, then shift the next result bit in.
    always_comb begin
        w_tens_adj = r_acc[7:4];
        w_ones_adj = r_acc[3:0];
        if (r_acc[7:4] >= 4'd5) begin
            w_tens_adj = r_acc[7:4] + 4'd3;
        end
        if (r_acc[3:0] >= 4'd5) begin
            w_ones_adj = r_acc[3:0] + 4'd3;
        end
        // The tens MSB shifts out; it is always zero for results up to 63.
        w_unused_tens_msb = w_tens_adj[3];
        w_acc_next        = {w_tens_adj[2:0], w_ones_adj, r_shift[WIDTH-1]};
    end

    // Digit patterns for the finished accumulator, with optional leading-zero blanking.
    always_comb begin
        w_seg_ones = seg7(r_acc[3:0]);
        w_seg_tens = seg7(r_acc[7:4]);
        if ((BLANK_LZ != 0) && (r_acc[7:4] == 4'd0)) begin
            w_seg_tens = 7'h7F;
        end
    end

    // Capture / convert / update sequencer with registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_iter  <= '0;
            segA    <= 7'h7F;
            segB    <= 7'h7F;
            bcd     <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Presses are honoured only here, so any strobe while busy is dropped.
                    if (r_press) begin
                        r_shift <= result;
                        r_acc   <= '0;
                        r_iter  <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 1;
                    if (r_iter == IT_LAST) begin
                        r_state <= S_UPDATE;
                    end else begin
                        r_iter <= r_iter + IT_W'(1);
                    end
                end
                S_UPDATE: begin
                    bcd     <= r_acc;
                    segA    <= w_seg_tens;
                    segB    <= w_seg_ones;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_display_latch.sv
// Bench for result_display_latch: table vectors, randomized presses against a
// decimal reference model, and hand-written bounce / busy / reset sequences.
module tb_result_display_latch;

    localparam int W  = 4;
    localparam int DC = 4;
    // Edges from driving btn_n low until done: 2 sync + DC debounce + WIDTH + 2.
    localparam int DONE_EDGE   = 2 + DC + W + 2;
    localparam int DONE_EDGE_F = 2 + 1 + 6 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       btn_n;
    logic       btn_f_n;
    logic [3:0] result;
    logic [5:0] result_f;

    logic [6:0] seg_a, seg_b, n_seg_a, n_seg_b, f_seg_a, f_seg_b;
    logic [7:0] bcd, n_bcd, f_bcd;
    logic       busy, done, n_busy, n_done, f_busy, f_done;

    int n_vec  = 0;
    int n_miss = 0;

    logic [6:0] seg_tab [10];

    // Main DUT: WIDTH=4, DEBOUNCE_CYCLES=4, blanking on.
    result_display_latch #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .result(result), .btn_n(btn_n),
        .segA(seg_a), .segB(seg_b), .bcd(bcd), .busy(busy), .done(done)
    );

    // Same stimulus, leading zero shown.
    result_display_latch #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .BLANK_LZ(0)) u_nolz (
        .clk(clk), .rst_n(rst_n), .result(result), .btn_n(btn_n),
        .segA(n_seg_a), .segB(n_seg_b), .bcd(n_bcd), .busy(n_busy), .done(n_done)
    );

    // Fast debounce, long conversion: lets a second press land while busy.
    result_display_latch #(.WIDTH(6), .DEBOUNCE_CYCLES(1), .BLANK_LZ(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .result(result_f), .btn_n(btn_f_n),
        .segA(f_seg_a), .segB(f_seg_b), .bcd(f_bcd), .busy(f_busy), .done(f_done)
    );

    typedef struct {
        int         res;
        logic [7:0] exp_bcd;
        logic [6:0] exp_sega;
        logic [6:0] exp_segb;
        logic [6:0] exp_sega_nolz;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain decimal split of the captured value.
    function automatic logic [7:0] model_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [6:0] model_tens(input int v, input bit blank);
        if (blank && (v / 10) == 0) return 7'h7F;
        return seg_tab[v / 10];
    endfunction

    function automatic logic [6:0] model_ones(input int v);
        return seg_tab[v % 10];
    endfunction

    // Hold the button low for 10 cycles and watch 40 edges for done/busy.
    task automatic press_main(input int val, input bit perturb,
                              output int n_done_o, output int first_done, output int n_busy_o);
        result     = 4'(val);
        btn_n      = 1'b0;
        n_done_o   = 0;
        first_done = -1;
        n_busy_o   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 10) btn_n = 1'b1;
            if (perturb && k == 7) result = 4'($urandom_range(0, 15));
            if (done) begin
                n_done_o++;
                if (first_done < 0) first_done = k;
            end
            if (busy) n_busy_o++;
        end
        $display("press result=%0d bcd=%02h segA=%07b segB=%07b done_edge=%0d",
                 val, bcd, seg_a, seg_b, first_done);
    endtask

    initial begin
        int nd, fd, nb, v, cnt_d, cnt_b;
        logic [7:0] held;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        vecs[0] = '{13, 8'h13, 7'b1111001, 7'b0110000, 7'b1111001};
        vecs[1] = '{0,  8'h00, 7'b1111111, 7'b1000000, 7'b1000000};
        vecs[2] = '{15, 8'h15, 7'b1111001, 7'b0010010, 7'b1111001};
        vecs[3] = '{9,  8'h09, 7'b1111111, 7'b0010000, 7'b1000000};
        vecs[4] = '{10, 8'h10, 7'b1111001, 7'b1000000, 7'b1111001};

        rst_n    = 1'b0;
        btn_n    = 1'b1;
        btn_f_n  = 1'b1;
        result   = 4'd0;
        result_f = 6'd0;

        // Reset held with the button chattering.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            btn_n = ~btn_n;
        end
        chk("reset_segA", seg_a, 7'h7F);
        chk("reset_segB", seg_b, 7'h7F);
        chk("reset_bcd", bcd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        btn_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_d = 0; cnt_b = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) cnt_d++;
            if (busy) cnt_b++;
        end
        chk("post_reset_no_done", cnt_d, 0);
        chk("post_reset_no_busy", cnt_b, 0);
        $display("reset sequence done_pulses=%0d busy_cycles=%0d", cnt_d, cnt_b);

        // Directed table vectors.
        for (int i = 0; i < 5; i++) begin
            press_main(vecs[i].res, 1'b0, nd, fd, nb);
            chk("tbl_bcd", bcd, vecs[i].exp_bcd);
            chk("tbl_segA", seg_a, vecs[i].exp_sega);
            chk("tbl_segB", seg_b, vecs[i].exp_segb);
            chk("tbl_segA_nolz", n_seg_a, vecs[i].exp_sega_nolz);
            chk("tbl_bcd_nolz", n_bcd, vecs[i].exp_bcd);
            chk("tbl_done_count", nd, 1);
            chk("tbl_done_edge", fd, DONE_EDGE);
            chk("tbl_busy_cycles", nb, W + 1);
        end

        // Bounce: two 3-cycle low glitches, never DC stable cycles.
        held = bcd;
        cnt_d = 0; cnt_b = 0;
        for (int k = 0; k < 40; k++) begin
            btn_n = ((k < 3) || (k >= 5 && k < 8)) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (done) cnt_d++;
            if (busy) cnt_b++;
        end
        chk("bounce_no_done", cnt_d, 0);
        chk("bounce_no_busy", cnt_b, 0);
        chk("bounce_bcd_held", bcd, held);
        $display("bounce sequence done_pulses=%0d busy_cycles=%0d bcd=%02h", cnt_d, cnt_b, bcd);

        // Randomized presses; result scrambled after capture.
        for (int i = 0; i < 10; i++) begin
            v = $urandom_range(0, 15);
            press_main(v, 1'b1, nd, fd, nb);
            chk("rnd_bcd", bcd, model_bcd(v));
            chk("rnd_segA", seg_a, model_tens(v, 1'b1));
            chk("rnd_segB", seg_b, model_ones(v));
            chk("rnd_segA_nolz", n_seg_a, model_tens(v, 1'b0));
            chk("rnd_done_count", nd, 1);
        end

        // Busy interaction: second debounced press lands during conversion.
        result_f = 6'd7;
        btn_f_n  = 1'b0;
        cnt_d = 0; cnt_b = 0; fd = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                result_f = 6'd9;
                btn_f_n  = 1'b1;
            end
            if (k == 6) btn_f_n = 1'b0;
            if (k == 14) btn_f_n = 1'b1;
            if (f_done) begin
                cnt_d++;
                if (fd < 0) fd = k;
            end
            if (f_busy) cnt_b++;
        end
        chk("busy_bcd", f_bcd, 8'h07);
        chk("busy_segA", f_seg_a, 7'h7F);
        chk("busy_segB", f_seg_b, 7'b1111000);
        chk("busy_done_count", cnt_d, 1);
        chk("busy_done_edge", fd, DONE_EDGE_F);
        chk("busy_cycles", cnt_b, 7);
        $display("busy sequence bcd=%02h done_pulses=%0d busy_cycles=%0d", f_bcd, cnt_d, cnt_b);

        // Reset in the second CONVERT cycle.
        result = 4'd5;
        btn_n  = 1'b0;
        cnt_d = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 8) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_segA", seg_a, 7'h7F);
                chk("midrst_segB", seg_b, 7'h7F);
                chk("midrst_bcd", bcd, 0);
                chk("midrst_busy", busy, 0);
            end
            if (k == 10) btn_n = 1'b1;
            if (k == 12) rst_n = 1'b1;
            if (done) cnt_d++;
        end
        chk("midrst_no_done", cnt_d, 0);
        $display("mid-conversion reset done_pulses=%0d bcd=%02h", cnt_d, bcd);

        press_main(12, 1'b0, nd, fd, nb);
        chk("after_rst_bcd", bcd, 8'h12);
        chk("after_rst_segA", seg_a, 7'b1111001);
        chk("after_rst_segB", seg_b, 7'b0100100);
        chk("after_rst_done_count", nd, 1);
        chk("after_rst_done_edge", fd, DONE_EDGE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
